// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encodings and datapath widths.
package hazard_pkg;

    localparam int REG_IDX_W   = 4;
    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_LDSTALL = 2'b01,
        ST_MEMWAIT = 2'b10,
        ST_FLUSH   = 2'b11
    } state_e;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use hazard detect: the load in execute writes a register that the
// instruction in decode reads. Register 0 is hard-wired, so it never
// creates a dependency.
module hazard_cmp
    import hazard_pkg::*;
(
    input  logic [REG_IDX_W-1:0] rs1_i,
    input  logic [REG_IDX_W-1:0] rs2_i,
    input  logic [REG_IDX_W-1:0] rd_i,
    input  logic                 mem_read_i,
    output logic                 load_use_o
);

    assign load_use_o = mem_read_i && (rd_i != '0) &&
                        ((rd_i == rs1_i) || (rd_i == rs2_i));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls on load-use and memory-busy, flushes
// on taken branches. Optional stall statistics counter is enabled by
// defining HAZARD_STATS_EN; otherwise StallCount is tied to zero.
//
// state   | meaning
// --------+------------------------------------------------------------
// RUN     | normal flow; evaluates MemBusy > BranchTaken > load-use
// LDSTALL | extra load-use bubbles; counter holds remaining bubbles
// MEMWAIT | holding pipeline until MemBusy is sampled low
// FLUSH   | second bubble cycle after a taken branch, PC/IF-ID advance
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LOADUSE_BUBBLES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REG_IDX_W-1:0]   IFID_rs1,
    input  logic [REG_IDX_W-1:0]   IFID_rs2,
    input  logic [REG_IDX_W-1:0]   IDEX_rd,
    input  logic                   IDEX_MemRead,
    input  logic                   BranchTaken,
    input  logic                   MemBusy,
    output logic                   PCWrite,
    output logic                   IFIDWrite,
    output logic                   IFIDFlush,
    output logic                   Delay,
    output logic [1:0]             State_out,
    output logic [STALL_CNT_W-1:0] StallCount
);

    localparam logic [1:0] BUB_LOAD = 2'(LOADUSE_BUBBLES - 1);

    state_e     state_q, state_d;
    logic [1:0] bub_q, bub_d;
    logic       load_use;

    hazard_cmp u_cmp (
        .rs1_i      (IFID_rs1),
        .rs2_i      (IFID_rs2),
        .rd_i       (IDEX_rd),
        .mem_read_i (IDEX_MemRead),
        .load_use_o (load_use)
    );

    // State and bubble counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            bub_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
        end
    end

    // Next-state and pipeline control outputs; reset forces a bubble.
    always_comb begin
        state_d   = state_q;
        bub_d     = bub_q;
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IFIDFlush = 1'b0;
        Delay     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (MemBusy) begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    Delay     = 1'b1;
                    state_d   = ST_MEMWAIT;
                end else if (BranchTaken) begin
                    IFIDFlush = 1'b1;
                    Delay     = 1'b1;
                    state_d   = ST_FLUSH;
                end else if (load_use) begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    Delay     = 1'b1;
                    if (LOADUSE_BUBBLES > 1) begin
                        state_d = ST_LDSTALL;
                        bub_d   = BUB_LOAD;
                    end
                end
            end
            ST_LDSTALL: begin
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
                Delay     = 1'b1;
                if (MemBusy) begin
                    state_d = ST_MEMWAIT;
                    bub_d   = 2'd0;
                end else if (bub_q <= 2'd1) begin
                    // Terminal count: never decrement below one.
                    state_d = ST_RUN;
                    bub_d   = 2'd0;
                end else begin
                    bub_d = bub_q - 2'd1;
                end
            end
            ST_MEMWAIT: begin
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
                Delay     = 1'b1;
                if (!MemBusy) begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                Delay   = 1'b1;
                state_d = MemBusy ? ST_MEMWAIT : ST_RUN;
            end
        endcase
        if (reset) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IFIDFlush = 1'b1;
            Delay     = 1'b1;
        end
    end

    assign State_out = state_q;

`ifdef HAZARD_STATS_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles with the PC held (reset cycles excluded).
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!PCWrite && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Statistics counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
`else
    assign StallCount = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (LOADUSE_BUBBLES=2). The reference
// model tracks pending bubbles, memory wait and flush as plain flags and
// integers; expected outputs follow the priority rules directly.
module tb_hazard_ctrl;

    localparam int LB = 2;
`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  IFID_rs1 = '0, IFID_rs2 = '0, IDEX_rd = '0;
    logic        IDEX_MemRead = 1'b0, BranchTaken = 1'b0, MemBusy = 1'b0;
    logic        PCWrite, IFIDWrite, IFIDFlush, Delay;
    logic [1:0]  State_out;
    logic [15:0] StallCount;

    hazard_ctrl #(.LOADUSE_BUBBLES(LB)) dut (
        .clk          (clk),
        .reset        (reset),
        .IFID_rs1     (IFID_rs1),
        .IFID_rs2     (IFID_rs2),
        .IDEX_rd      (IDEX_rd),
        .IDEX_MemRead (IDEX_MemRead),
        .BranchTaken  (BranchTaken),
        .MemBusy      (MemBusy),
        .PCWrite      (PCWrite),
        .IFIDWrite    (IFIDWrite),
        .IFIDFlush    (IFIDFlush),
        .Delay        (Delay),
        .State_out    (State_out),
        .StallCount   (StallCount)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model
    int m_bub = 0;
    bit m_mw  = 1'b0;
    bit m_fl  = 1'b0;
    int m_cnt = 0;

    // last observed outputs, for directed sequence checks
    logic        o_pcw, o_fl, o_dl;
    logic [1:0]  o_st;
    logic [15:0] o_cnt;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input bit rst, input bit mb, input bit br, input bit mr,
                       input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
        bit hz;
        bit e_pcw, e_ifw, e_fl, e_dl;
        int e_st, nb;
        bit nmw, nfl;
        reset = rst; MemBusy = mb; BranchTaken = br; IDEX_MemRead = mr;
        IDEX_rd = rd; IFID_rs1 = rs1; IFID_rs2 = rs2;
        @(negedge clk);
        hz   = mr && (rd != 0) && (rd == rs1 || rd == rs2);
        e_st = m_mw ? 2 : (m_fl ? 3 : (m_bub > 0 ? 1 : 0));
        e_pcw = 1; e_ifw = 1; e_fl = 0; e_dl = 0;
        nb = m_bub; nmw = m_mw; nfl = 0;
        if (rst) begin
            e_pcw = 0; e_ifw = 0; e_fl = 1; e_dl = 1;
            nb = 0; nmw = 0;
        end else if (m_mw) begin
            e_pcw = 0; e_ifw = 0; e_dl = 1;
            nmw = mb;
        end else if (m_fl) begin
            e_dl = 1;
            nmw = mb;
        end else if (m_bub > 0) begin
            e_pcw = 0; e_ifw = 0; e_dl = 1;
            if (mb) begin nb = 0; nmw = 1; end
            else nb = m_bub - 1;
        end else if (mb) begin
            e_pcw = 0; e_ifw = 0; e_dl = 1;
            nmw = 1;
        end else if (br) begin
            e_fl = 1; e_dl = 1; nfl = 1;
        end else if (hz) begin
            e_pcw = 0; e_ifw = 0; e_dl = 1;
            nb = LB - 1;
        end
        chk("PCWrite",    32'(PCWrite),    32'(e_pcw));
        chk("IFIDWrite",  32'(IFIDWrite),  32'(e_ifw));
        chk("IFIDFlush",  32'(IFIDFlush),  32'(e_fl));
        chk("Delay",      32'(Delay),      32'(e_dl));
        chk("State_out",  32'(State_out),  32'(e_st));
        chk("StallCount", 32'(StallCount), 32'(m_cnt));
        o_pcw = PCWrite; o_fl = IFIDFlush; o_dl = Delay;
        o_st = State_out; o_cnt = StallCount;
        @(posedge clk);
        m_bub = nb; m_mw = nmw; m_fl = nfl;
        if (rst) m_cnt = 0;
        else if (STATS && !e_pcw && m_cnt < 65535) m_cnt++;
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 4'd0, 4'd0, 4'd0);
    endtask

    initial begin
        int n_dl, n_fl, n_pc0;
        logic [3:0] rd, rs1, rs2;

        repeat (2) @(posedge clk);
        #1;

        // reset state
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rst_state", 32'(o_st), 32'd0);
        chk("rst_flush", 32'(o_fl), 32'd1);
        idle();
        chk("post_rst_pcw", 32'(o_pcw), 32'd1);

        // load-use with two bubbles: 00, 01, 00
        n_dl = 0; n_pc0 = 0;
        cyc(0, 0, 0, 1, 4'd3, 4'd5, 4'd3);
        chk("lu_st0", 32'(o_st), 32'd0);
        n_dl += int'(o_dl); n_pc0 += int'(!o_pcw);
        idle();
        chk("lu_st1", 32'(o_st), 32'd1);
        n_dl += int'(o_dl); n_pc0 += int'(!o_pcw);
        idle();
        chk("lu_st2", 32'(o_st), 32'd0);
        n_dl += int'(o_dl); n_pc0 += int'(!o_pcw);
        chk("lu_delay_cycles", 32'(n_dl), 32'd2);
        chk("lu_stall_cycles", 32'(n_pc0), 32'd2);

        // R0 never causes a stall
        cyc(0, 0, 0, 1, 4'd0, 4'd0, 4'd0);
        chk("r0_delay", 32'(o_dl), 32'd0);
        chk("r0_pcw", 32'(o_pcw), 32'd1);

        // taken branch beats load-use
        n_dl = 0; n_fl = 0; n_pc0 = 0;
        cyc(0, 0, 1, 1, 4'd3, 4'd3, 4'd0);
        n_dl += int'(o_dl); n_fl += int'(o_fl); n_pc0 += int'(!o_pcw);
        idle();
        n_dl += int'(o_dl); n_fl += int'(o_fl); n_pc0 += int'(!o_pcw);
        idle();
        n_dl += int'(o_dl); n_fl += int'(o_fl); n_pc0 += int'(!o_pcw);
        chk("br_flush_cycles", 32'(n_fl), 32'd1);
        chk("br_delay_cycles", 32'(n_dl), 32'd2);
        chk("br_pc_stalls", 32'(n_pc0), 32'd0);

        // memory wait arriving during LDSTALL
        cyc(0, 0, 0, 1, 4'd3, 4'd3, 4'd3);
        n_pc0 = 0;
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("mw_ldstall", 32'(o_st), 32'd1);
        n_pc0 += int'(!o_pcw);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("mw_entered", 32'(o_st), 32'd2);
        n_pc0 += int'(!o_pcw);
        cyc(0, 1, 0, 0, 0, 0, 0);
        n_pc0 += int'(!o_pcw);
        idle();
        n_pc0 += int'(!o_pcw);
        idle();
        n_pc0 += int'(!o_pcw);
        chk("mw_stall_cycles", 32'(n_pc0), 32'd4);
        chk("mw_run", 32'(o_st), 32'd0);

        // reset pulse in the middle of MEMWAIT
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("rmw_in_memwait", 32'(o_st), 32'd2);
        cyc(1, 1, 0, 0, 0, 0, 0);
        idle();
        chk("rmw_state", 32'(o_st), 32'd0);
        chk("rmw_cnt", 32'(o_cnt), 32'd0);
        chk("rmw_pcw", 32'(o_pcw), 32'd1);

        // five stall cycles
        repeat (4) cyc(0, 1, 0, 0, 0, 0, 0);
        idle();
        idle();
        chk("stats_five", 32'(o_cnt), STATS ? 32'd5 : 32'd0);

        // saturation
        repeat (65540) cyc(0, 1, 0, 0, 0, 0, 0);
        idle();
        chk("stats_sat", 32'(o_cnt), STATS ? 32'hFFFF : 32'd0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        idle();
        chk("stats_sat_hold", 32'(o_cnt), STATS ? 32'hFFFF : 32'd0);

        // randomized traffic
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            rd  = 4'($urandom_range(0, 15));
            rs1 = ($urandom_range(0, 2) == 0) ? rd : 4'($urandom_range(0, 15));
            rs2 = ($urandom_range(0, 2) == 0) ? rd : 4'($urandom_range(0, 15));
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), rd, rs1, rs2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter LOADUSE_BUBBLES SHALL be: default 1; legal range 1..3; number of bubble cycles inserted per load-use hazard.
REQ-002 Port clk SHALL be: input, 1 bit, single clock for all state.
REQ-003 Port reset SHALL be: input, 1 bit, synchronous active-high reset sampled on the rising edge of clk.
REQ-004 Port IFID_rs1 SHALL be: input, 4 bits, source register 1 of the instruction in decode.
REQ-005 Port IFID_rs2 SHALL be: input, 4 bits, source register 2 of the instruction in decode.
REQ-006 Port IDEX_rd SHALL be: input, 4 bits, destination register of the instruction in execute.
REQ-007 Port IDEX_MemRead SHALL be: input, 1 bit, instruction in execute is a load.
REQ-008 Port BranchTaken SHALL be: input, 1 bit, branch resolved taken in execute this cycle.
REQ-009 Port MemBusy SHALL be: input, 1 bit, data memory is not ready.
REQ-010 Port PCWrite SHALL be: output, 1 bit, PC update enable.
REQ-011 Port IFIDWrite SHALL be: output, 1 bit, IF/ID register write enable.
REQ-012 Port IFIDFlush SHALL be: output, 1 bit, clears IF/ID to a NOP.
REQ-013 Port Delay SHALL be: output, 1 bit, drives the Delay input of the control-zeroing mux (1 = bubble into ID/EX).
REQ-014 Port State_out SHALL be: output, 2 bits, current FSM state.
REQ-015 Port StallCount SHALL be: output, 16 bits, stall statistics counter.

Function
REQ-016 The FSM SHALL have the states RUN=00, LDSTALL=01, MEMWAIT=10 and FLUSH=11.
REQ-017 A load-use hazard SHALL be IDEX_MemRead=1 and IDEX_rd!=0 and (IDEX_rd==IFID_rs1 or IDEX_rd==IFID_rs2).
REQ-018 Outputs SHALL be combinational from the current state and inputs, with the defaults PCWrite=1, IFIDWrite=1, IFIDFlush=0 and Delay=0.
REQ-019 In RUN, the priority SHALL be MemBusy > BranchTaken > load-use.
REQ-020 In RUN with MemBusy=1, the outputs SHALL be PCWrite=0, IFIDWrite=0 and Delay=1, and the next state SHALL be MEMWAIT.
REQ-021 In RUN with BranchTaken=1 (and MemBusy=0), the outputs SHALL be IFIDFlush=1 and Delay=1, and the next state SHALL be FLUSH; a simultaneous load-use hazard SHALL be dropped.
REQ-022 In RUN with a load-use hazard only, the outputs SHALL be PCWrite=0, IFIDWrite=0 and Delay=1; the next state SHALL be RUN if LOADUSE_BUBBLES==1, otherwise LDSTALL with the bubble counter loaded to LOADUSE_BUBBLES-1.
REQ-023 LDSTALL SHALL output PCWrite=0, IFIDWrite=0 and Delay=1; it SHALL go to RUN when the counter equals 1, otherwise decrement the counter.
REQ-024 The total bubble cycles per load-use hazard SHALL be exactly LOADUSE_BUBBLES.
REQ-025 MEMWAIT SHALL output PCWrite=0, IFIDWrite=0 and Delay=1 every cycle, and SHALL go to RUN on the first cycle in which MemBusy is sampled 0.
REQ-026 FLUSH SHALL output Delay=1 with PCWrite=1 and IFIDWrite=1 for one cycle, then go to RUN.
REQ-027 MemBusy=1 in LDSTALL or FLUSH SHALL move the FSM to MEMWAIT next and discard the remaining bubble count.
REQ-028 BranchTaken and load-use SHALL be ignored outside RUN.
REQ-029 The bubble counter SHALL be 2 bits and SHALL never wrap below 1 while in LDSTALL.

Reset
REQ-030 While reset=1, the outputs SHALL be PCWrite=0, IFIDWrite=0, IFIDFlush=1 and Delay=1.
REQ-031 Reset SHALL set state=RUN, the bubble counter to 0 and StallCount to 0.
REQ-032 The first cycle after reset deasserts SHALL be RUN with default outputs (subject to inputs).
REQ-033 Reset mid-LDSTALL or mid-MEMWAIT SHALL abort the sequence with no residual bubbles.

Configuration
REQ-034 With macro HAZARD_STATS_EN defined, StallCount SHALL increment on every cycle with PCWrite=0 (reset excluded) and saturate at 16'hFFFF.
REQ-035 Without HAZARD_STATS_EN, StallCount SHALL be tied to 16'h0000 and no counter register SHALL be instantiated.

Structure
REQ-036 A shared package hazard_pkg SHALL hold the state encodings, REG_IDX_W=4 and STALL_CNT_W=16.
REQ-037 One combinational sub-module, hazard_cmp, SHALL compute the load-use detect (REQ-017); the FSM and counters SHALL reside in hazard_ctrl.

Verification
REQ-038 The bench SHALL check load-use: IDEX_MemRead=1, IDEX_rd=3, IFID_rs2=3, LOADUSE_BUBBLES=2 -> Delay=1 and PCWrite=0 for exactly 2 cycles, with State_out 00,01,00.
REQ-039 The bench SHALL check the R0 exclusion: IDEX_MemRead=1, IDEX_rd=0, IFID_rs1=0 -> no stall, Delay=0.
REQ-040 The bench SHALL check branch priority: BranchTaken=1 together with a load-use hazard -> IFIDFlush=1 for 1 cycle, Delay=1 for 2 cycles, PCWrite stays 1.
REQ-041 The bench SHALL check a memory wait: MemBusy=1 for 3 cycles during LDSTALL -> MEMWAIT entered, stall lasts 4 cycles, then RUN.
REQ-042 The bench SHALL check reset mid-MEMWAIT: reset pulsed for 1 cycle -> State_out=00, StallCount=0, and PCWrite=1 on the next cycle.
REQ-043 The bench SHALL check statistics with HAZARD_STATS_EN defined: 5 stall cycles -> StallCount=5; with the counter preset to FFFF -> it stays FFFF.
